// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared FSM state type and parameter legal ranges for seq_detect_prog
package seq_detect_pkg;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 16;
   localparam int CNT_W_MIN   = 1;
   localparam int CNT_W_MAX   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      HUNT  = 2'b01,
      MATCH = 2'b10
   } state_t;

endpackage

// File: rtl/seq_detect_prog_if.sv
// rtl/seq_detect_prog_if.sv - serial stream, pattern load and match status bundle for seq_detect_prog
interface seq_detect_prog_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
);

   logic               in;
   logic               in_valid;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_data;
   logic               overlap;
   logic               out;
   logic [CNT_W-1:0]   match_cnt;
   logic               busy;

   modport master (
      output in, in_valid, pat_load, pat_data, overlap,
      input  out, match_cnt, busy
   );

   modport slave (
      input  in, in_valid, pat_load, pat_data, overlap,
      output out, match_cnt, busy
   );

endinterface

// File: rtl/seq_hist_sreg.sv
// rtl/seq_hist_sreg.sv - history shift register plus saturating fill counter
// hist_nxt and full describe the state as it would be once din is shifted in.
module seq_hist_sreg
   import seq_detect_pkg::*;
#(
   parameter int PAT_LEN = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift,
   input  logic               clear_fill,
   input  logic               din,
   output logic [PAT_LEN-1:0] hist_nxt,
   output logic               full
);

   localparam int FW = $clog2(PAT_LEN + 1);

   logic [PAT_LEN-1:0] hist;
   logic [FW-1:0]      fill;
   logic [FW-1:0]      fill_inc;

   if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
      $error("seq_hist_sreg: PAT_LEN out of range");
   end

   assign hist_nxt = {hist[PAT_LEN-2:0], din};
   assign fill_inc = (fill == FW'(PAT_LEN)) ? fill : fill + 1'b1;
   assign full     = (fill_inc == FW'(PAT_LEN));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= hist_nxt;
         fill <= clear_fill ? '0 : fill_inc;
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with optional match counter
// Define SEQ_DETECT_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] DEF_PAT = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input logic               clk,
   input logic               rst,
   seq_detect_prog_if.slave  bus
);

   state_t             state;
   state_t             state_nxt;
   logic [PAT_LEN-1:0] pat;
   logic [PAT_LEN-1:0] hist_nxt;
   logic               full;
   logic               consume;
   logic               hit;

   if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("seq_detect_prog: CNT_W out of range");
   end

   // A bit arriving alongside pat_load belongs to the old pattern and is dropped.
   assign consume = bus.in_valid && !bus.pat_load;
   assign hit     = consume && full && (hist_nxt == pat);

   seq_hist_sreg #(
      .PAT_LEN (PAT_LEN)
   ) u_hist (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.pat_load),
      .shift      (consume),
      .clear_fill (hit && !bus.overlap),
      .din        (bus.in),
      .hist_nxt   (hist_nxt),
      .full       (full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pat   <= DEF_PAT;
      end else begin
         state <= state_nxt;
         if (bus.pat_load) begin
            pat <= bus.pat_data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = HUNT;
         HUNT:    if (hit) state_nxt = MATCH;
         MATCH:   state_nxt = hit ? MATCH : HUNT;
         default: state_nxt = IDLE;
      endcase
      if (bus.pat_load) begin
         state_nxt = HUNT;
      end
   end

   assign bus.out  = (state == MATCH);
   assign bus.busy = (state == HUNT);

`ifdef SEQ_DETECT_CNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state_nxt == MATCH && cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.match_cnt = cnt;
`else
   assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed checks of seq_detect_prog (CNT_W=8 and CNT_W=2 instances)
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_b = 1'b0;
   logic       vld = 1'b0;
   logic       pl = 1'b0;
   logic [3:0] pd = 4'b0000;
   logic       ov = 1'b1;
   int         total = 0;
   int         bad = 0;
   int         nm = 0;

   always #5 clk = ~clk;

   seq_detect_prog_if #(.PAT_LEN(4), .CNT_W(8)) bus_a ();
   seq_detect_prog_if #(.PAT_LEN(4), .CNT_W(2)) bus_b ();

   assign bus_a.in       = in_b;
   assign bus_a.in_valid = vld;
   assign bus_a.pat_load = pl;
   assign bus_a.pat_data = pd;
   assign bus_a.overlap  = ov;
   assign bus_b.in       = in_b;
   assign bus_b.in_valid = vld;
   assign bus_b.pat_load = pl;
   assign bus_b.pat_data = pd;
   assign bus_b.overlap  = ov;

   seq_detect_prog #(.PAT_LEN(4), .DEF_PAT(4'b1011), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   seq_detect_prog #(.PAT_LEN(4), .DEF_PAT(4'b1011), .CNT_W(2)) u_dut_c2 (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int ecnt(input int n, input int w);
`ifdef SEQ_DETECT_CNT_EN
      return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
`else
      return 0;
`endif
   endfunction

   task automatic step(input logic b, input logic v);
      in_b = b;
      vld  = v;
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         step(bits[n-1-i], 1'b1);
         chk($sformatf("%s_out%0d", tag, i), 32'(bus_a.out), 32'(exp[n-1-i]));
      end
      vld = 1'b0;
   endtask

   task automatic load(input logic [3:0] p, input string tag);
      pl = 1'b1;
      pd = p;
      step(1'b0, 1'b0);
      pl = 1'b0;
      chk($sformatf("%s_out", tag), 32'(bus_a.out), 0);
      chk($sformatf("%s_busy", tag), 32'(bus_a.busy), 1);
   endtask

   task automatic chk_cnt(input string tag);
      chk($sformatf("%s_cnt", tag), 32'(bus_a.match_cnt), ecnt(nm, 8));
      chk($sformatf("%s_cnt2", tag), 32'(bus_b.match_cnt), ecnt(nm, 2));
   endtask

   initial begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("rst_out", 32'(bus_a.out), 0);
      chk("rst_busy", 32'(bus_a.busy), 0);
      chk_cnt("rst");
      rst = 1'b0;
      step(1'b0, 1'b0);
      chk("hunt_busy", 32'(bus_a.busy), 1);

      stream(16'b1011, 4, 16'b0001, "basic");
      nm = 1;
      chk_cnt("basic");
      step(1'b0, 1'b0);
      chk("match_drop", 32'(bus_a.out), 0);

      load(4'b1011, "ld_ovl");
      ov = 1'b1;
      stream(16'b1011011, 7, 16'b0001001, "ovl");
      nm = 3;
      chk_cnt("ovl");

      load(4'b1011, "ld_novl");
      ov = 1'b0;
      stream(16'b1011011, 7, 16'b0001000, "novl");
      nm = 4;
      chk_cnt("novl");

      load(4'b1011, "ld_gap");
      ov = 1'b1;
      stream(16'b10, 2, 16'b00, "gap_a");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("gap_idle%0d", i), 32'(bus_a.out), 0);
      end
      stream(16'b11, 2, 16'b01, "gap_b");
      nm = 5;
      chk_cnt("gap");

      pl = 1'b1;
      pd = 4'b0110;
      step(1'b0, 1'b1);
      pl = 1'b0;
      vld = 1'b0;
      chk("disc_out", 32'(bus_a.out), 0);
      chk("disc_busy", 32'(bus_a.busy), 1);
      stream(16'b110, 3, 16'b000, "disc");
      load(4'b0110, "ld_new");
      stream(16'b0110, 4, 16'b0001, "newpat");
      nm = 6;
      chk_cnt("newpat");

      stream(16'b101, 3, 16'b000, "pre_rst");
      rst = 1'b1;
      pl  = 1'b1;
      pd  = 4'b0110;
      step(1'b0, 1'b1);
      rst = 1'b0;
      pl  = 1'b0;
      vld = 1'b0;
      nm  = 0;
      chk("mrst_out", 32'(bus_a.out), 0);
      chk("mrst_busy", 32'(bus_a.busy), 0);
      chk_cnt("mrst");
      stream(16'b1, 1, 16'b0, "post_rst");
      stream(16'b011, 3, 16'b001, "def_pat");
      nm = 1;
      chk_cnt("def_pat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter DEF_PAT, default 4'b1011: pattern loaded at reset, PAT_LEN bits wide.
REQ-003 Parameter CNT_W, default 8: match counter width, legal range 1..16.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in  input  1: serial data bit.
REQ-007 in_valid  input  1: qualifies in; the bit is consumed only when high.
REQ-008 pat_load  input  1: load pat_data as the new pattern.
REQ-009 pat_data  input  PAT_LEN: pattern; MSB is the first bit of the sequence.
REQ-010 overlap  input  1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 out  output  1: registered match pulse.
REQ-012 match_cnt  output  CNT_W: saturating count of matches.
REQ-013 busy  output  1: high while the block is in the HUNT state.

Function
REQ-014 The block SHALL keep a PAT_LEN-bit history register; each consumed bit shifts in at the LSB.
REQ-015 The block SHALL keep a fill counter of consumed bits, saturating at PAT_LEN.
REQ-016 The block SHALL have a 3-state FSM with states IDLE, HUNT and MATCH.
REQ-017 From IDLE, the FSM SHALL go to HUNT on the first cycle after reset with rst low.
REQ-018 From HUNT, the FSM SHALL go to MATCH when a consumed bit completes the pattern: the updated history equals the pattern and the updated fill equals PAT_LEN.
REQ-019 From MATCH, the FSM SHALL go back to HUNT after one cycle, or stay in MATCH if that cycle's consumed bit completes another match.
REQ-020 out SHALL be 1 exactly when the FSM is in MATCH (Moore output), giving one-cycle latency after the completing bit.
REQ-021 Overlapping mode (overlap=1): the history and fill SHALL be kept after a match, so "1011011" with pattern 1011 gives 2 matches.
REQ-022 Non-overlapping mode (overlap=0): the fill SHALL be cleared after a match, so "1011011" gives 1 match.
REQ-023 When in_valid is low, the history, fill and FSM SHALL hold, except that MATCH still returns to HUNT.
REQ-024 A pat_load SHALL, on the next edge, load the pattern, clear the history and fill, force the FSM to HUNT and drive out to 0.
REQ-025 When pat_load and in_valid are high in the same cycle, pat_load SHALL win and the in bit SHALL be discarded.
REQ-026 overlap SHALL be sampled on the cycle a match completes; changing it mid-stream SHALL take effect at the next match.
REQ-027 match_cnt SHALL increment by 1 on each entry into or re-assertion of MATCH.
REQ-028 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 pat_load SHALL NOT clear match_cnt.

Reset
REQ-030 On rst=1 at an edge, the block SHALL set the FSM to IDLE, history and fill to 0, pattern to DEF_PAT, out to 0, match_cnt to 0 and busy to 0.
REQ-031 rst SHALL take priority over pat_load and in_valid, and a reset mid-sequence SHALL discard all partial progress.

Configuration
REQ-032 When macro SEQ_DETECT_CNT_EN is defined, the block SHALL implement the match counter as in REQ-027 to REQ-029.
REQ-033 When SEQ_DETECT_CNT_EN is undefined, match_cnt SHALL be constant 0, no counter flops SHALL be inferred, and all other behaviour SHALL be unchanged.

Structure
REQ-034 The package seq_detect_pkg SHALL hold the FSM state typedef (IDLE=2'b00, HUNT=2'b01, MATCH=2'b10) and the PAT_LEN/CNT_W legal-range constants.
REQ-035 The block SHALL contain one sub-module, seq_hist_sreg, holding the history shift register and fill counter, with shift-enable, clear and full outputs.

Verification
REQ-036 Reset, then stream 1,0,1,1 with in_valid=1 -> out=1 for the cycle after the 4th bit, and match_cnt=1.
REQ-037 overlap=1, stream 1011011 -> out pulses after bits 4 and 7, and match_cnt=2; repeat with overlap=0 -> a single pulse after bit 4.
REQ-038 Stream 1,0, drop in_valid for 3 cycles, then 1,1 -> the match completes on the last bit, with no spurious pulse during the gap.
REQ-039 pat_load=1 with pat_data=4'b0110 and in_valid=1 in the same cycle -> the bit is discarded; the next stream 0110 -> match.
REQ-040 CNT_W=2, 5 matches -> match_cnt holds at 3; rst mid-pattern after 1,0,1 -> then "1" gives no match.
REQ-041 Build without SEQ_DETECT_CNT_EN, run scenario REQ-037 -> identical out waveform, with match_cnt=0 throughout.
